// File: rtl/godai_arb_pkg.sv
// Shared types for the Godai two-to-one memory-port arbiter.
package godai_arb_pkg;
  typedef enum logic { OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1 } owner_e;
  typedef enum logic [1:0] { LOCK_NONE, LOCK_INSTR, LOCK_DATA } lock_e;
endpackage

// File: rtl/godai_owner_fifo.sv
// In-order owner FIFO: one owner bit per granted transaction awaiting its response.
module godai_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] store;
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Payload storage carries no reset; validity comes from the count.
  always_ff @(posedge clk) begin
    if (push) store[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = store[rptr_q];
endmodule

// File: rtl/godai_mem_arbiter.sv
// Two-to-one instr/data memory-port arbiter with in-order response steering.
// Define GODAI_ARB_RR_EN for round-robin; otherwise data has fixed priority.
module godai_mem_arbiter
  import godai_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic                    mem_err_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    arb_busy_o,
  output logic                    protocol_err_o
);
  lock_e  lock_q;
  owner_e sel_owner;
  owner_e both_pick;
  logic   sel_req;
  logic   grant;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_head;
  logic   pop;

`ifdef GODAI_ARB_RR_EN
  owner_e last_q;
  assign both_pick = (last_q == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_q <= OWNER_INSTR;
    else if (grant) last_q <= sel_owner;
  end
`else
  assign both_pick = OWNER_DATA;
`endif

  // A locked side keeps the port until its request is granted.
  always_comb begin
    sel_owner = OWNER_INSTR;
    case (lock_q)
      LOCK_INSTR: sel_owner = OWNER_INSTR;
      LOCK_DATA:  sel_owner = OWNER_DATA;
      default: begin
        if (data_req_i && instr_req_i) sel_owner = both_pick;
        else if (data_req_i)           sel_owner = OWNER_DATA;
      end
    endcase
  end

  assign sel_req     = (sel_owner == OWNER_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o   = sel_req && !fifo_full && rst_n;
  assign grant       = mem_gnt_i && mem_req_o;
  assign instr_gnt_o = grant && (sel_owner == OWNER_INSTR);
  assign data_gnt_o  = grant && (sel_owner == OWNER_DATA);

  assign mem_we_o    = (sel_owner == OWNER_DATA) ? data_we_i    : 1'b0;
  assign mem_be_o    = (sel_owner == OWNER_DATA) ? data_be_i    : '1;
  assign mem_addr_o  = (sel_owner == OWNER_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = (sel_owner == OWNER_DATA) ? data_wdata_i : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= LOCK_NONE;
    end else begin
      case (lock_q)
        LOCK_NONE: begin
          if (sel_req && !grant)
            lock_q <= (sel_owner == OWNER_DATA) ? LOCK_DATA : LOCK_INSTR;
        end
        default: if (grant) lock_q <= LOCK_NONE;
      endcase
    end
  end

  godai_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (grant),
    .push_data(sel_owner == OWNER_DATA),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign pop            = mem_rvalid_i && !fifo_empty;
  assign instr_rvalid_o = pop && (fifo_head == OWNER_INSTR);
  assign data_rvalid_o  = pop && (fifo_head == OWNER_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign data_err_o     = mem_err_i && data_rvalid_o;
  assign arb_busy_o     = !fifo_empty || mem_req_o;

  // A response with nothing outstanding means the memory and arbiter disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          protocol_err_o <= 1'b0;
    else if (mem_rvalid_i && fifo_empty) protocol_err_o <= 1'b1;
  end
endmodule

// File: tb/tb_godai_mem_arbiter.sv
// Bench for godai_mem_arbiter: queue-based reference model plus directed literal checks.
module tb_godai_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_req_i = 0, data_req_i = 0, data_we_i = 0;
  logic [AW-1:0] instr_addr_i = '0, data_addr_i = '0;
  logic [BW-1:0] data_be_i = '0;
  logic [DW-1:0] data_wdata_i = '0, mem_rdata_i = '0;
  logic          mem_gnt_i = 0, mem_rvalid_i = 0, mem_err_i = 0;
  logic          instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, data_err_o;
  logic [DW-1:0] instr_rdata_o, data_rdata_o, mem_wdata_o;
  logic          mem_req_o, mem_we_o, arb_busy_o, protocol_err_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;

  godai_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
    .mem_rdata_i(mem_rdata_i), .arb_busy_o(arb_busy_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding owners in a queue (0=instr, 1=data).
  int owner_q[$];
  int locked_side = -1;
  int last_side = 0;
  bit perr = 1'b0;

  task automatic model_step();
    bit sel, req, mreq, gnt, full;
    int own;
    if (!rst_n) begin
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_instr_gnt", instr_gnt_o, 0);
      chk("rst_data_gnt", data_gnt_o, 0);
      chk("rst_instr_rvalid", instr_rvalid_o, 0);
      chk("rst_data_rvalid", data_rvalid_o, 0);
      chk("rst_busy", arb_busy_o, 0);
      chk("rst_perr", protocol_err_o, 0);
      owner_q.delete();
      locked_side = -1;
      last_side = 0;
      perr = 1'b0;
      return;
    end
    full = (owner_q.size() >= MO);
    if (locked_side >= 0) sel = (locked_side == 1);
    else if (data_req_i && instr_req_i) begin
`ifdef GODAI_ARB_RR_EN
      sel = (last_side == 0);
`else
      sel = 1'b1;
`endif
    end else sel = data_req_i;
    req  = sel ? data_req_i : instr_req_i;
    mreq = req && !full;
    gnt  = mreq && mem_gnt_i;
    chk("mem_req", mem_req_o, mreq);
    chk("instr_gnt", instr_gnt_o, gnt && !sel);
    chk("data_gnt", data_gnt_o, gnt && sel);
    if (mreq) begin
      chk("mem_addr", mem_addr_o, sel ? data_addr_i : instr_addr_i);
      chk("mem_we", mem_we_o, sel ? data_we_i : 1'b0);
      chk("mem_be", mem_be_o, sel ? data_be_i : {BW{1'b1}});
      chk("mem_wdata", mem_wdata_o, sel ? data_wdata_i : '0);
    end
    own = -1;
    if (mem_rvalid_i && owner_q.size() > 0) own = owner_q[0];
    chk("instr_rvalid", instr_rvalid_o, own == 0);
    chk("data_rvalid", data_rvalid_o, own == 1);
    chk("data_err", data_err_o, (own == 1) && mem_err_i);
    if (own >= 0) begin
      chk("instr_rdata", instr_rdata_o, mem_rdata_i);
      chk("data_rdata", data_rdata_o, mem_rdata_i);
    end
    chk("busy", arb_busy_o, (owner_q.size() > 0) || mreq);
    chk("perr", protocol_err_o, perr);
    // Advance to the state after the coming rising edge.
    if (mem_rvalid_i && owner_q.size() == 0) perr = 1'b1;
    if (own >= 0) void'(owner_q.pop_front());
    if (gnt) begin
      owner_q.push_back(sel ? 1 : 0);
      last_side = sel ? 1 : 0;
    end
    if (locked_side < 0) locked_side = (req && !gnt) ? (sel ? 1 : 0) : -1;
    else if (gnt) locked_side = -1;
  endtask

  always @(negedge clk) begin
    #2;
    model_step();
  end

  task automatic idle();
    instr_req_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Literal checks land after the model's sample point in the same cycle.
  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    next(); idle(); rst_n = 0;
    next(); next(); rst_n = 1;
  endtask

  logic exp_d;

  initial begin
    idle();
    repeat (2) next();
    rst_n = 1;

    // Single instruction read.
    next(); instr_req_i = 1; instr_addr_i = 32'h20; mem_gnt_i = 1;
    settle();
    chk("t1_instr_gnt", instr_gnt_o, 1);
    chk("t1_addr", mem_addr_o, 32'h20);
    next(); idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    settle();
    chk("t1_instr_rvalid", instr_rvalid_o, 1);
    chk("t1_instr_rdata", instr_rdata_o, 32'h13);
    chk("t1_data_rvalid", data_rvalid_o, 0);

    // Both sides requesting continuously.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      next(); idle();
      instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = (i > 0);
      instr_addr_i = 32'h400; data_addr_i = 32'h800;
      settle();
`ifdef GODAI_ARB_RR_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      chk("t2_data_gnt", data_gnt_o, exp_d);
      chk("t2_instr_gnt", instr_gnt_o, !exp_d);
    end

    // Lock holds instr selection while data arrives.
    do_reset();
    instr_addr_i = 32'h100; data_addr_i = 32'h200;
    for (int i = 0; i < 3; i++) begin
      next(); idle(); instr_req_i = 1; data_req_i = (i >= 1);
      settle();
      chk("t3_addr_locked", mem_addr_o, 32'h100);
      chk("t3_no_gnt", instr_gnt_o | data_gnt_o, 0);
    end
    next(); instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
    settle();
    chk("t3_instr_gnt", instr_gnt_o, 1);
    chk("t3_addr_instr", mem_addr_o, 32'h100);
    next(); instr_req_i = 0; data_req_i = 1; mem_gnt_i = 1;
    settle();
    chk("t3_data_gnt", data_gnt_o, 1);
    chk("t3_addr_data", mem_addr_o, 32'h200);

    // Outstanding limit.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      next(); idle(); instr_req_i = 1; mem_gnt_i = 1;
      settle();
      chk("t4_grant", instr_gnt_o, 1);
    end
    next(); settle();
    chk("t4_blocked", mem_req_o, 0);
    next(); mem_rvalid_i = 1; settle();
    chk("t4_blocked_on_pop", mem_req_o, 0);
    chk("t4_pop_rvalid", instr_rvalid_o, 1);
    next(); mem_rvalid_i = 0; settle();
    chk("t4_reassert", mem_req_o, 1);

    // Error routing.
    do_reset();
    next(); data_req_i = 1; mem_gnt_i = 1; data_addr_i = 32'h300;
    next(); idle(); mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'hdead;
    settle();
    chk("t5_data_rvalid", data_rvalid_o, 1);
    chk("t5_data_err", data_err_o, 1);
    next(); idle(); instr_req_i = 1; mem_gnt_i = 1;
    next(); idle(); mem_rvalid_i = 1; mem_err_i = 1;
    settle();
    chk("t5_instr_rvalid", instr_rvalid_o, 1);
    chk("t5_err_dropped", data_err_o, 0);

    // Protocol error and mid-transaction reset.
    do_reset();
    next(); mem_rvalid_i = 1; settle();
    chk("t6_no_rvalid", instr_rvalid_o | data_rvalid_o, 0);
    for (int i = 0; i < 3; i++) begin
      next(); idle(); settle();
      chk("t6_perr_sticky", protocol_err_o, 1);
    end
    next(); instr_req_i = 1; mem_gnt_i = 1;
    next(); rst_n = 0; mem_rvalid_i = 1; settle();
    chk("t6_rst_req", mem_req_o, 0);
    chk("t6_rst_gnt", instr_gnt_o, 0);
    chk("t6_rst_rvalid", instr_rvalid_o, 0);
    chk("t6_rst_busy", arb_busy_o, 0);
    chk("t6_rst_perr", protocol_err_o, 0);
    next(); idle(); rst_n = 1;
    next(); mem_rvalid_i = 1; settle();
    chk("t6_fifo_cleared", instr_rvalid_o, 0);
    next(); idle(); settle();
    chk("t6_perr_again", protocol_err_o, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      next();
      rst_n        = ($urandom_range(0, 399) != 0);
      instr_req_i  = ($urandom_range(0, 3) != 0);
      data_req_i   = ($urandom_range(0, 2) != 0);
      instr_addr_i = $urandom;
      data_addr_i  = $urandom;
      data_we_i    = $urandom_range(0, 1);
      data_be_i    = BW'($urandom_range(0, (1 << BW) - 1));
      data_wdata_i = $urandom;
      mem_gnt_i    = $urandom_range(0, 1);
      mem_rvalid_i = (owner_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_err_i    = ($urandom_range(0, 3) == 0);
      mem_rdata_i  = $urandom;
    end
    next(); idle(); rst_n = 1;
    next(); next();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/godai_mem_arbiter.md
# godai_mem_arbiter

Two-to-one memory-port arbiter placed between the Godai core's instruction and data memory interfaces and a single shared memory port (req/gnt/rvalid protocol). Selects one requester per cycle, holds the selection stable until granted, and records each granted transaction's owner in an in-order FIFO so `mem_rvalid_i` responses are steered to the requester that issued them. Lets the core run against one single-ported RAM.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width; byte enables are `DATA_WIDTH/8` bits.
- `MAX_OUTSTANDING`, default 2: owner-FIFO depth, i.e. the maximum number of granted transactions awaiting rvalid. Must be ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_req_i` / `instr_gnt_o` / `instr_rvalid_o`  in/out/out  1  instruction-side handshake.
- `instr_addr_i`  in  ADDR_WIDTH  fetch address.
- `instr_rdata_o`  out  DATA_WIDTH  fetch data.
- `data_req_i` / `data_gnt_o` / `data_rvalid_o`  in/out/out  1  data-side handshake.
- `data_we_i`  in  1  write enable.
- `data_be_i`  in  DATA_WIDTH/8  byte enables.
- `data_addr_i`  in  ADDR_WIDTH  data address.
- `data_wdata_i`  in  DATA_WIDTH  write data.
- `data_rdata_o`  out  DATA_WIDTH  read data.
- `data_err_o`  out  1  error flag, valid with `data_rvalid_o`.
- `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o`  out  shared-port request fields.
- `mem_gnt_i`, `mem_rvalid_i`, `mem_err_i`  in  1  shared-port handshake.
- `mem_rdata_i`  in  DATA_WIDTH  shared-port read data.
- `arb_busy_o`  out  1  owner FIFO non-empty or `mem_req_o` high.
- `protocol_err_o`  out  1  sticky; set by `mem_rvalid_i` while the owner FIFO is empty.

## Operation
- Lock register, three states: NONE, INSTR, DATA.
  - NONE with a request present: select per the arbitration policy. If `mem_gnt_i` does not follow in the same cycle, move to INSTR/DATA.
  - INSTR/DATA: selection is forced to the locked side. Return to NONE on `mem_gnt_i`.
- Instruction requests drive `mem_we_o=0`, `mem_be_o` all ones, and `mem_wdata_o=0`.
- `mem_req_o` = selected request AND NOT fifo_full AND `rst_n`.
- The selected side's `*_gnt_o` = `mem_gnt_i && mem_req_o`. The other side's grant is 0.
- On grant, push the owner bit (0=instr, 1=data) into the FIFO.
- On `mem_rvalid_i`, pop the FIFO head and assert the owner's `*_rvalid_o`.
  - `mem_rdata_i` fans out to both `*_rdata_o`.
  - `data_err_o = mem_err_i && owner==data`. `mem_err_i` on an instruction response is dropped.
- `mem_rvalid_i` with the FIFO empty: no `*_rvalid_o`, set `protocol_err_o`. Only reset clears it.
- Same-cycle push and pop: both occur and the count is unchanged. Full is evaluated on the registered count, so a full FIFO blocks the request even in a cycle that pops.
- Responses are strictly in grant order. Count width is `$clog2(MAX_OUTSTANDING+1)` and the pointers wrap modulo `MAX_OUTSTANDING`.

## Timing
- Request-to-`mem_req_o`: 0 cycles (combinational).
- Grant and rvalid routing: 0 cycles (combinational).
- State updates on the clk rising edge: lock, FIFO, RR pointer, `protocol_err_o`.
- Reset values: lock NONE, FIFO empty, RR pointer = instr-last (data favoured first), `protocol_err_o=0`. `mem_req_o`, `*_gnt_o`, `*_rvalid_o` and `arb_busy_o` are 0 while `rst_n` is low.
- Reset mid-operation clears the FIFO, so in-flight responses are lost. The memory must be reset together with the arbiter.
- Throughput: one grant per cycle when `mem_gnt_i` is held high and the FIFO is not full.

## Configuration
- `GODAI_ARB_RR_EN` defined: round-robin. When both sides request in NONE, the side not granted last wins. The last-granted pointer updates on every grant.
- Not defined: fixed priority. Data always wins in NONE. The pointer logic is absent.
- The lock rule applies in both modes.

## Structure
- `godai_arb_pkg`:
  - `owner_e` enum (OWNER_INSTR=0, OWNER_DATA=1).
  - `lock_e` enum (LOCK_NONE, LOCK_INSTR, LOCK_DATA).
- One sub-module, `godai_owner_fifo`: parameterised by depth, 1-bit payload, with push, pop, full, empty and head outputs.

## Test plan
- Single instruction read at address 0x20, `mem_gnt_i` same cycle, rvalid 1 cycle later with 0x00000013 -> `instr_gnt_o` pulses, `instr_rvalid_o=1`, `instr_rdata_o=0x13`, `data_rvalid_o=0`.
- Both sides request continuously with `mem_gnt_i=1`:
  - fixed mode -> data granted every cycle and instr starved;
  - RR mode -> grants alternate D, I, D, I.
- Instr request with `mem_gnt_i` low for 3 cycles while data rises in cycle 1 -> `mem_addr_o` stays at the instr address until granted, then data is granted.
- `MAX_OUTSTANDING=2`, two grants, no rvalid -> `mem_req_o` drops to 0 on the third request; it re-asserts the cycle after the first rvalid.
- Data read, rvalid with `mem_err_i=1` -> `data_err_o=1`. The same on an instr response -> no error output and `instr_rvalid_o=1`.
- `mem_rvalid_i` after reset with no grant -> `protocol_err_o=1` and stays 1. Assert `rst_n` low mid-transaction -> all outputs 0 and the FIFO is empty.
